// File: rtl/axi_addr_xbar.sv
// axi_addr_xbar: N-master to M-slave AXI address-channel crossbar with round-robin grant lock
// Ports: clk, rst (async active-low); per-master id/addr/len/size/burst/valid in, ready out;
// broadcast id_s_o ({master index, id}) and payload out, one-hot valid_s_o out, ready_s_i in.
// Build option: define AXI_XBAR_REGSLICE_EN to place a 2-entry skid buffer before the slave ports.
module axi_addr_xbar #(
   parameter int NUM_M = 3,
   parameter int NUM_S = 8,
   parameter int ID_W = 4,
   parameter int IDS_W = ID_W + $clog2(NUM_M),
   parameter int ADDR_W = 32,
   parameter int LEN_W = 4,
   parameter int SIZE_W = 3,
   parameter int BURST_W = 2,
   parameter logic [NUM_S-2:0][ADDR_W-1:0] S_BASE = '0,
   parameter logic [NUM_S-2:0][ADDR_W-1:0] S_MASK = '1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_M*ID_W-1:0]      id_m_i,
   input  logic [NUM_M*ADDR_W-1:0]    addr_m_i,
   input  logic [NUM_M*LEN_W-1:0]     len_m_i,
   input  logic [NUM_M*SIZE_W-1:0]    size_m_i,
   input  logic [NUM_M*BURST_W-1:0]   burst_m_i,
   input  logic [NUM_M-1:0]           valid_m_i,
   output logic [NUM_M-1:0]           ready_m_o,
   output logic [IDS_W-1:0]           id_s_o,
   output logic [ADDR_W-1:0]          addr_s_o,
   output logic [LEN_W-1:0]           len_s_o,
   output logic [SIZE_W-1:0]          size_s_o,
   output logic [BURST_W-1:0]         burst_s_o,
   output logic [NUM_S-1:0]           valid_s_o,
   input  logic [NUM_S-1:0]           ready_s_i
);
   localparam int GW = $clog2(NUM_M);
   localparam int SW = $clog2(NUM_S);
   typedef enum logic {IDLE, LOCK} state_t;
   state_t state;
   logic [GW-1:0] rr_ptr, grant, win;
   logic [SW-1:0] sel, win_sel;
   logic [ADDR_W-1:0] win_addr;
   logic lock, g_valid, accept;
   logic [ID_W-1:0] g_id;
   logic [ADDR_W-1:0] g_addr;
   logic [LEN_W-1:0] g_len;
   logic [SIZE_W-1:0] g_size;
   logic [BURST_W-1:0] g_burst;
   // Round-robin search: scanning from the far end backwards leaves the nearest requester to rr_ptr.
   always_comb begin
      win = '0;
      for (int i = NUM_M - 1; i >= 0; i--)
         if (valid_m_i[(int'(rr_ptr) + i) % NUM_M]) win = GW'((int'(rr_ptr) + i) % NUM_M);
   end
   // Decode: descending scan so the lowest matching region wins; no match falls to the default slave.
   always_comb begin
      win_addr = addr_m_i[int'(win)*ADDR_W +: ADDR_W];
      win_sel = SW'(NUM_S - 1);
      for (int s = NUM_S - 2; s >= 0; s--)
         if ((win_addr & S_MASK[s]) == S_BASE[s]) win_sel = SW'(s);
   end
   assign lock = state == LOCK;
   assign g_valid = valid_m_i[grant];
   assign g_id = id_m_i[int'(grant)*ID_W +: ID_W];
   assign g_addr = addr_m_i[int'(grant)*ADDR_W +: ADDR_W];
   assign g_len = len_m_i[int'(grant)*LEN_W +: LEN_W];
   assign g_size = size_m_i[int'(grant)*SIZE_W +: SIZE_W];
   assign g_burst = burst_m_i[int'(grant)*BURST_W +: BURST_W];
   // A dropped valid releases the lock without advancing rr_ptr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant <= '0;
         sel <= '0;
      end else if (state == IDLE) begin
         if (|valid_m_i) begin
            grant <= win;
            sel <= win_sel;
            state <= LOCK;
         end
      end else if (!g_valid) begin
         state <= IDLE;
      end else if (accept) begin
         rr_ptr <= (int'(grant) == NUM_M - 1) ? '0 : grant + 1'b1;
         state <= IDLE;
      end
   end
`ifdef AXI_XBAR_REGSLICE_EN
   typedef struct packed {
      logic [NUM_S-1:0]   oh;
      logic [IDS_W-1:0]   id;
      logic [ADDR_W-1:0]  addr;
      logic [LEN_W-1:0]   len;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
   } ent_t;
   ent_t e0, e1, din;
   logic [1:0] cnt;
   logic push, pop;
   // e0 is always the head; its one-hot is kept zero while empty so valid_s_o is a pure flop.
   assign accept = cnt != 2'd2;
   assign push = lock && g_valid && accept;
   assign pop = |(e0.oh & ready_s_i);
   assign din = '{oh: NUM_S'(1) << sel, id: {grant, g_id}, addr: g_addr, len: g_len, size: g_size, burst: g_burst};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e0 <= '0;
         e1 <= '0;
         cnt <= '0;
      end else begin
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            if (cnt == 2'd2) e0 <= e1;
            else if (push) e0 <= din;
            else e0.oh <= '0;
         end else if (push) begin
            if (cnt == 2'd0) e0 <= din;
            else e1 <= din;
         end
      end
   end
   assign ready_m_o = (lock && accept) ? NUM_M'(1) << grant : '0;
   assign valid_s_o = e0.oh;
   assign id_s_o = e0.id;
   assign addr_s_o = e0.addr;
   assign len_s_o = e0.len;
   assign size_s_o = e0.size;
   assign burst_s_o = e0.burst;
`else
   assign accept = ready_s_i[sel];
   assign ready_m_o = (lock && accept) ? NUM_M'(1) << grant : '0;
   assign valid_s_o = (lock && g_valid) ? NUM_S'(1) << sel : '0;
   assign id_s_o = lock ? {grant, g_id} : '0;
   assign addr_s_o = lock ? g_addr : '0;
   assign len_s_o = lock ? g_len : '0;
   assign size_s_o = lock ? g_size : '0;
   assign burst_s_o = lock ? g_burst : '0;
`endif
endmodule

// File: tb/tb_axi_addr_xbar.sv
// tb_axi_addr_xbar: directed and random stimulus for axi_addr_xbar against a transaction-level reference model
module tb_axi_addr_xbar;
   localparam int NM = 3, NS = 8, IW = 4, AW = 32, LW = 4, SZW = 3, BW = 2;
   localparam logic [NS-2:0][AW-1:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1234_0000,
                                             32'h0002_0000, 32'h0001_0000, 32'h1000_0000};
   localparam logic [NS-2:0][AW-1:0] MASK = {32'hFFFF_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFFFF_0000,
                                             32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
   logic clk = 1'b0, rst = 1'b0;
   logic [NM*IW-1:0] id_m_i = '0;
   logic [NM*AW-1:0] addr_m_i = '0;
   logic [NM*LW-1:0] len_m_i = '0;
   logic [NM*SZW-1:0] size_m_i = '0;
   logic [NM*BW-1:0] burst_m_i = '0;
   logic [NM-1:0] valid_m_i = '0, ready_m_o;
   logic [5:0] id_s_o;
   logic [AW-1:0] addr_s_o;
   logic [LW-1:0] len_s_o;
   logic [SZW-1:0] size_s_o;
   logic [BW-1:0] burst_s_o;
   logic [NS-1:0] valid_s_o, ready_s_i = '0;
   axi_addr_xbar #(.NUM_M(NM), .NUM_S(NS), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .SIZE_W(SZW),
                   .BURST_W(BW), .S_BASE(BASE), .S_MASK(MASK)) dut (
      .clk(clk), .rst(rst), .id_m_i(id_m_i), .addr_m_i(addr_m_i), .len_m_i(len_m_i),
      .size_m_i(size_m_i), .burst_m_i(burst_m_i), .valid_m_i(valid_m_i), .ready_m_o(ready_m_o),
      .id_s_o(id_s_o), .addr_s_o(addr_s_o), .len_s_o(len_s_o), .size_s_o(size_s_o),
      .burst_s_o(burst_s_o), .valid_s_o(valid_s_o), .ready_s_i(ready_s_i));
   always #5 clk = ~clk;
   int unsigned rb[7] = '{32'h1000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1234_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
   int unsigned rm[7] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFF00_0000, 32'hFFFF_0000};
   int unsigned pool[6] = '{32'h1000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1234_0000, 32'h3000_0000, 32'hDEAD_0000};
   int exp_rr[4] = '{2, 0, 1, 2};
   bit m_lock;
   int m_g, m_sel, m_ptr, hs_last, cyc, n_chk, n_fail;
   int hs_q[$], hs_t[$];
   function automatic int decode(logic [31:0] a);
      for (int s = 0; s < 7; s++) if ((a & rm[s]) == rb[s]) return s;
      return 7;
   endfunction
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      logic [7:0] ev = '0;
      logic [2:0] er = '0;
      logic [5:0] eid = '0;
      logic [31:0] ea = '0;
      logic [3:0] el = '0;
      logic [2:0] es = '0;
      logic [1:0] eb = '0;
      if (m_lock) begin
         ev = valid_m_i[m_g] ? 8'd1 << m_sel : 8'd0;
         er = ready_s_i[m_sel] ? 3'd1 << m_g : 3'd0;
         eid = {2'(m_g), id_m_i[m_g*IW +: IW]};
         ea = addr_m_i[m_g*AW +: AW];
         el = len_m_i[m_g*LW +: LW];
         es = size_m_i[m_g*SZW +: SZW];
         eb = burst_m_i[m_g*BW +: BW];
      end
      chk("valid_s", valid_s_o, ev);
      chk("ready_m", ready_m_o, er);
      chk("id_s", id_s_o, eid);
      chk("addr_s", addr_s_o, ea);
      chk("len_s", len_s_o, el);
      chk("size_s", size_s_o, es);
      chk("burst_s", burst_s_o, eb);
   endtask
   task automatic model_update();
      hs_last = -1;
      if (!rst) begin
         m_lock = 0;
         m_ptr = 0;
      end else if (!m_lock) begin
         if (valid_m_i != 0) begin
            for (int i = 0; i < NM; i++)
               if (valid_m_i[(m_ptr + i) % NM]) begin
                  m_g = (m_ptr + i) % NM;
                  break;
               end
            m_sel = decode(addr_m_i[m_g*AW +: AW]);
            m_lock = 1;
         end
      end else if (valid_m_i[m_g] && ready_s_i[m_sel]) begin
         hs_last = m_g;
         hs_q.push_back(m_g);
         hs_t.push_back(cyc);
         m_ptr = (m_g + 1) % NM;
         m_lock = 0;
      end else if (!valid_m_i[m_g]) begin
         m_lock = 0;
      end
   endtask
   task automatic cycle();
      #1 check_all();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
   endtask
   task automatic set_m(int k, logic v, logic [3:0] id, logic [31:0] a);
      valid_m_i[k] = v;
      id_m_i[k*IW +: IW] = id;
      addr_m_i[k*AW +: AW] = a;
      len_m_i[k*LW +: LW] = LW'($urandom);
      size_m_i[k*SZW +: SZW] = SZW'($urandom);
      burst_m_i[k*BW +: BW] = BW'($urandom);
   endtask
   initial begin
      int n;
      m_lock = 0; m_ptr = 0; m_g = 0; m_sel = 0; hs_last = -1; cyc = 0; n_chk = 0; n_fail = 0;
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b1;
      // single master to slave 1
      set_m(1, 1'b1, 4'h5, 32'h0001_0040);
      cycle();
      ready_s_i = 8'b0000_0010;
      #1 chk("single_valid_s", valid_s_o, 8'b0000_0010);
      chk("single_id_s", id_s_o, 6'b01_0101);
      chk("single_ready_m", ready_m_o, 3'b010);
      cycle();
      chk("single_handshake", hs_last, 1);
      valid_m_i = '0;
      ready_s_i = '1;
      cycle();
      // round robin from rr_ptr=2
      hs_q.delete();
      hs_t.delete();
      set_m(0, 1'b1, 4'h1, 32'h0001_0100);
      set_m(1, 1'b1, 4'h2, 32'h0002_0200);
      set_m(2, 1'b1, 4'h3, 32'h2000_0300);
      n = 0;
      while (hs_q.size() < 4 && n < 20) begin
         cycle();
         n++;
      end
      chk("rr_count", hs_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("rr_order", hs_q.size() > i ? hs_q[i] : -1, exp_rr[i]);
      for (int i = 0; i < 3; i++) chk("rr_spacing", hs_q.size() > i + 1 ? hs_t[i+1] - hs_t[i] : -1, 2);
      valid_m_i = '0;
      cycle();
      // backpressure on slave 2 while m1 also requests
      ready_s_i = 8'hFB;
      set_m(0, 1'b1, 4'h3, 32'h0002_0100);
      set_m(1, 1'b1, 4'h9, 32'h0001_0000);
      cycle();
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_valid_s2", valid_s_o, 8'b0000_0100);
         chk("bp_addr_stable", addr_s_o, 32'h0002_0100);
         chk("bp_ready_m", ready_m_o, 3'b000);
         cycle();
      end
      ready_s_i = '1;
      cycle();
      chk("bp_handshake", hs_last, 0);
      valid_m_i = '0;
      cycle();
      // default slave
      set_m(2, 1'b1, 4'h7, 32'hDEAD_0000);
      cycle();
      #1 chk("default_slave", valid_s_o, 8'b1000_0000);
      cycle();
      valid_m_i = '0;
      cycle();
      // overlapping regions 0 and 3
      set_m(0, 1'b1, 4'h1, 32'h1234_5678);
      cycle();
      #1 chk("overlap_slave0", valid_s_o, 8'b0000_0001);
      cycle();
      valid_m_i = '0;
      cycle();
      // master drops valid while locked
      ready_s_i = '0;
      set_m(1, 1'b1, 4'hA, 32'h0002_0000);
      cycle();
      valid_m_i = '0;
      cycle();
      chk("drop_no_handshake", hs_last, -1);
      cycle();
      // reset asserted mid-lock
      valid_m_i = 3'b111;
      cycle();
      cycle();
      rst = 1'b0;
      m_lock = 0;
      m_ptr = 0;
      #1 chk("rst_valid_s", valid_s_o, 8'h00);
      chk("rst_ready_m", ready_m_o, 3'b000);
      cycle();
      rst = 1'b1;
      ready_s_i = '1;
      cycle();
      #1 chk("rst_winner_m0", id_s_o[5:4], 2'd0);
      cycle();
      valid_m_i = '0;
      cycle();
      // random traffic; a master holds valid and payload until accepted
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NM; k++) begin
            if (hs_last == k) valid_m_i[k] = 1'b0;
            if (!valid_m_i[k] && $urandom_range(1, 0) == 1)
               set_m(k, 1'b1, 4'($urandom), $urandom_range(6, 0) == 6 ? $urandom : pool[$urandom_range(5, 0)] ^ ($urandom & 32'h0000_FFFF));
         end
         ready_s_i = 8'($urandom);
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
